// File: rtl/rst_button_hold_monitor.sv
// Front-panel reset button monitor: synchronizes and debounces the button, times the hold on
// the 32 kHz tick, and issues a fixed-width active-low reset request after a long press.
module rst_button_hold_monitor #(
    parameter int SYNC_STAGES    = 2,
    parameter int DEBOUNCE_TICKS = 16,
    parameter int HOLD_TICKS     = 131072,
    parameter int PULSE_TICKS    = 512
) (
    input  logic MCLKi,
    input  logic SysReset,
    input  logic Tick32K,
    input  logic RstBtn_N,
    input  logic FM_PS_EN,
    output logic BtnDebounced,
    output logic ShortPress,
    output logic LongPress,
    output logic ResetOut_ox
);

    localparam int DEB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HOLD_W  = $clog2(HOLD_TICKS + 1);
    localparam int PULSE_W = $clog2(PULSE_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        FIRE,
        WAIT_REL
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   btn_s;
    logic [DEB_W-1:0]       deb_cnt_q;

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [PULSE_W-1:0]     pulse_cnt_q, pulse_cnt_d;
    logic                   short_press;

    // Synchronizer presets to "released" so a reset never looks like a press.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge MCLKi) begin
        if (SysReset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RstBtn_N};
        end
    end

    assign btn_s = ~sync_q[SYNC_STAGES-1];

    always_ff @(posedge MCLKi) begin
        if (SysReset) begin
            deb_cnt_q    <= '0;
            BtnDebounced <= 1'b0;
        end else if (btn_s == BtnDebounced) begin
            deb_cnt_q <= '0;
        end else if (deb_cnt_q == DEB_W'(DEBOUNCE_TICKS)) begin
            BtnDebounced <= btn_s;
            deb_cnt_q    <= '0;
        end else if (Tick32K) begin
            deb_cnt_q <= deb_cnt_q + DEB_W'(1);
        end
    end

    always_ff @(posedge MCLKi) begin
        if (SysReset) begin
            state_q     <= IDLE;
            hold_cnt_q  <= '0;
            pulse_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_cnt_q  <= hold_cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        hold_cnt_d  = hold_cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        short_press = 1'b0;

        case (state_q)
            IDLE: begin
                hold_cnt_d  = '0;
                pulse_cnt_d = '0;
                if (BtnDebounced) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Threshold is tested before release so a coincident release still fires.
                if (hold_cnt_q == HOLD_W'(HOLD_TICKS)) begin
                    state_d     = FIRE;
                    pulse_cnt_d = '0;
                end else if (!BtnDebounced) begin
                    short_press = 1'b1;
                    state_d     = IDLE;
                    hold_cnt_d  = '0;
                end else if (Tick32K) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            FIRE: begin
                if (pulse_cnt_q == PULSE_W'(PULSE_TICKS)) begin
                    state_d = WAIT_REL;
                end else if (Tick32K) begin
                    pulse_cnt_d = pulse_cnt_q + PULSE_W'(1);
                end
            end
            WAIT_REL: begin
                if (!BtnDebounced) begin
                    state_d     = IDLE;
                    hold_cnt_d  = '0;
                    pulse_cnt_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (!FM_PS_EN) begin
            state_d     = IDLE;
            hold_cnt_d  = '0;
            pulse_cnt_d = '0;
            short_press = 1'b0;
        end
    end

    // Outputs are gated by FM_PS_EN combinationally so a power-off releases the request at once.
    assign ShortPress  = short_press;
    assign LongPress   = FM_PS_EN && ((state_q == FIRE) || (state_q == WAIT_REL));
    assign ResetOut_ox = !(FM_PS_EN && (state_q == FIRE));

endmodule
